// File: rtl/interpreter_pkg.sv
// Shared opcodes, error byte, FSM state type and argument-length helper for the UART command interpreter.
package interpreter_pkg;

  localparam logic [7:0] OP_RESET  = 8'h01;
  localparam logic [7:0] OP_STEP   = 8'h02;
  localparam logic [7:0] OP_RD_REG = 8'h03;
  localparam logic [7:0] OP_WR_REG = 8'h04;
  localparam logic [7:0] OP_RD_MEM = 8'h05;
  localparam logic [7:0] OP_WR_MEM = 8'h06;
  localparam logic [7:0] OP_RD_ALU = 8'h07;
  localparam logic [7:0] ERR_CODE  = 8'hEE;

  typedef enum logic [2:0] {IDLE, ARGS, EXEC, MEM_WAIT, PULSE, SEND} state_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_RESET) && (op <= OP_RD_ALU);
  endfunction

  function automatic logic [3:0] arg_bytes(input logic [7:0] op, input int db, input int ab);
    case (op)
      OP_STEP, OP_RD_REG: return 4'd1;
      OP_WR_REG:          return 4'(1 + db);
      OP_RD_MEM:          return 4'(ab);
      OP_WR_MEM:          return 4'(ab + db);
      default:            return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/reply_serializer.sv
// Reply shift register: loads one byte or a full data word and pushes it MSB first to the TX FIFO,
// one byte per cycle while tx_full=0; tx_data holds while the FIFO is full.
module reply_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  single,
  input  logic [7:0]            byte_in,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  tx_full,
  output logic [7:0]            tx_data,
  output logic                  tx_write,
  output logic                  done
);

  localparam int DB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] sh_q, sh_d, byte_aligned;
  logic [3:0]            cnt_q, cnt_d;

  // A single byte is left-justified so it leaves first like the top byte of a word.
  assign byte_aligned = DATA_WIDTH'(byte_in) << (DATA_WIDTH - 8);
  assign tx_data      = sh_q[DATA_WIDTH-1 -: 8];
  assign tx_write     = (cnt_q != 4'd0) && !tx_full;
  assign done         = tx_write && (cnt_q == 4'd1);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = single ? byte_aligned : word_in;
      cnt_d = single ? 4'd1 : 4'(DB);
    end else if (tx_write) begin
      sh_d  = sh_q << 8;
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/command_interpreter.sv
// UART debug command interpreter: decodes opcode+argument bytes and drives core reset/step, registers and memory.
// Optional inter-byte timeout in ARGS is built only when CMD_TIMEOUT_EN is defined.
module command_interpreter
  import interpreter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int RESET_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_empty,
  input  logic [7:0]                rx_data,
  output logic                      rx_read,
  input  logic                      tx_full,
  output logic [7:0]                tx_data,
  output logic                      tx_write,
  output logic                      core_reset,
  output logic                      core_clk_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_num,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic                      reg_write,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  output logic                      mem_req,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int DB    = DATA_WIDTH / 8;
  localparam int AB    = ADDR_WIDTH / 8;
  localparam int ARG_W = ADDR_WIDTH + DATA_WIDTH;

  state_t                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [ARG_W-1:0]      arg_q, arg_d;
  logic [3:0]            left_q, left_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  ser_load, ser_single, ser_done;
  logic [7:0]            ser_byte;
  logic [DATA_WIDTH-1:0] ser_word;
`ifdef CMD_TIMEOUT_EN
  logic [31:0]           to_q, to_d;
`endif

  // Argument fields are packed LSB-aligned in arrival order, so the last-received field sits lowest.
  assign reg_num     = (op_q == OP_WR_REG) ? arg_q[8*DB +: REG_ADDR_WIDTH] : arg_q[REG_ADDR_WIDTH-1:0];
  assign reg_wdata   = arg_q[DATA_WIDTH-1:0];
  assign mem_addr    = (op_q == OP_WR_MEM) ? arg_q[DATA_WIDTH +: ADDR_WIDTH] : arg_q[ADDR_WIDTH-1:0];
  assign mem_wdata   = arg_q[DATA_WIDTH-1:0];
  assign mem_req     = (state_q == MEM_WAIT);
  assign mem_we      = mem_req && (op_q == OP_WR_MEM);
  assign core_reset  = (state_q == PULSE) && (op_q == OP_RESET);
  assign core_clk_en = (state_q == PULSE) && (op_q == OP_STEP);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    left_d     = left_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    rx_read    = 1'b0;
    reg_write  = 1'b0;
    ser_load   = 1'b0;
    ser_single = 1'b1;
    ser_byte   = op_q;
    ser_word   = '0;
`ifdef CMD_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      IDLE: if (!rx_empty && !reset) begin
        rx_read = 1'b1;
        op_d    = rx_data;
        phase_d = 1'b0;
        left_d  = arg_bytes(rx_data, DB, AB);
`ifdef CMD_TIMEOUT_EN
        to_d    = '0;
`endif
        if (!op_known(rx_data)) begin
          ser_load = 1'b1;
          ser_byte = ERR_CODE;
          state_d  = SEND;
        end else if (arg_bytes(rx_data, DB, AB) == 4'd0) begin
          state_d = EXEC;
        end else begin
          state_d = ARGS;
        end
      end
      ARGS: if (!rx_empty && !reset) begin
        rx_read = 1'b1;
        arg_d   = {arg_q[ARG_W-9:0], rx_data};
        left_d  = left_q - 4'd1;
`ifdef CMD_TIMEOUT_EN
        to_d    = '0;
`endif
        if (left_q == 4'd1) state_d = EXEC;
      end
`ifdef CMD_TIMEOUT_EN
      else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
        ser_load = 1'b1;
        ser_byte = ERR_CODE;
        state_d  = SEND;
      end else begin
        to_d = to_q + 32'd1;
      end
`endif
      EXEC: case (op_q)
        OP_RESET: begin
          cnt_d   = 32'(RESET_CYCLES);
          state_d = PULSE;
        end
        OP_STEP: if (arg_q[7:0] == 8'd0) begin
          ser_load = 1'b1;
          state_d  = SEND;
        end else begin
          cnt_d   = {24'd0, arg_q[7:0]};
          state_d = PULSE;
        end
        // reg_rdata follows reg_num by one cycle, so the capture waits a second EXEC cycle.
        OP_RD_REG: if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          ser_load   = 1'b1;
          ser_single = 1'b0;
          ser_word   = reg_rdata;
          state_d    = SEND;
        end
        OP_WR_REG: begin
          reg_write = 1'b1;
          ser_load  = 1'b1;
          state_d   = SEND;
        end
        OP_RD_MEM, OP_WR_MEM: state_d = MEM_WAIT;
        OP_RD_ALU: begin
          ser_load   = 1'b1;
          ser_single = 1'b0;
          ser_word   = alu_result;
          state_d    = SEND;
        end
        default: state_d = IDLE;
      endcase
      MEM_WAIT: if (mem_ack) begin
        ser_load = 1'b1;
        if (op_q == OP_RD_MEM) begin
          ser_single = 1'b0;
          ser_word   = mem_rdata;
        end
        state_d = SEND;
      end
      PULSE: if (cnt_q == 32'd1) begin
        ser_load = 1'b1;
        state_d  = SEND;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
      SEND: if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      arg_q   <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`endif

  reply_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .single   (ser_single),
    .byte_in  (ser_byte),
    .word_in  (ser_word),
    .tx_full  (tx_full),
    .tx_data  (tx_data),
    .tx_write (tx_write),
    .done     (ser_done)
  );

endmodule
